// File: rtl/rect_reader.sv
// rect_reader: walks a span/skip/repeat region issuing single-word VRAM reads,
// queues the returned words in a CPU-drained FIFO and keeps a running 16-bit checksum.
module rect_reader #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rd_active,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_valid,
    input  logic [15:0] mem_din,
    input  logic [1:0]  wr,
    input  logic        rd,
    input  logic [15:0] address,
    input  logic [15:0] din,
    output logic [15:0] dout
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        r_state;
    logic [15:0]   r_span, r_skip, r_repeat, r_start;
    logic [15:0]   r_addr, r_span_cnt, r_row_cnt, r_sum, r_dout;
    logic          r_mem_rd, r_last;
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_sel, w_cnt4;
    logic          w_idle, w_start, w_push, w_pop, w_empty, w_full, w_room;
    logic [CW-1:0] w_cnt_next;
    logic [15:0]   w_status, w_rdata;

    assign w_sel      = address[3:0];
    assign w_idle     = r_state == IDLE;
    assign w_start    = w_idle && wr[0] && w_sel == 4'd7 && din[0];
    assign w_push     = r_state == WAIT && mem_valid;
    assign w_empty    = r_cnt == '0;
    assign w_full     = r_cnt == CW'(FIFO_DEPTH);
    assign w_pop      = rd && w_sel == 4'd5 && !w_empty;
    assign w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);
    // Issue only when the word it fetches is guaranteed a FIFO slot.
    assign w_room     = w_cnt_next < CW'(FIFO_DEPTH);
    assign w_cnt4     = 4'(r_cnt);
    assign w_status   = {8'h00, w_cnt4, 1'b0, w_full, w_empty, rd_active};

    assign rd_active = !w_idle;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_addr;
    assign dout      = r_dout;

    function automatic logic [15:0] f_bmask(input logic [15:0] old);
        return {wr[1] ? din[15:8] : old[15:8], wr[0] ? din[7:0] : old[7:0]};
    endfunction

    always_comb begin
        case (w_sel)
            4'd0:    w_rdata = r_span;
            4'd1:    w_rdata = r_skip;
            4'd2:    w_rdata = r_repeat;
            4'd3:    w_rdata = r_start;
            4'd4:    w_rdata = r_sum;
            4'd5:    w_rdata = w_empty ? 16'h0000 : r_fifo[r_rp];
            4'd6:    w_rdata = w_status;
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_span     <= '0;
            r_skip     <= '0;
            r_repeat   <= '0;
            r_start    <= '0;
            r_addr     <= '0;
            r_span_cnt <= '0;
            r_row_cnt  <= '0;
            r_sum      <= '0;
            r_dout     <= '0;
            r_mem_rd   <= 1'b0;
            r_last     <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
        end else begin
            r_dout <= w_rdata;
            if (w_idle && w_sel == 4'd0) r_span <= f_bmask(r_span);
            if (w_idle && w_sel == 4'd1) r_skip <= f_bmask(r_skip);
            if (w_idle && w_sel == 4'd2) r_repeat <= f_bmask(r_repeat);
            if (w_idle && w_sel == 4'd3) r_start <= f_bmask(r_start);
            if (w_start) begin
                r_state    <= ISSUE;
                r_mem_rd   <= 1'b1;
                r_addr     <= r_start;
                r_span_cnt <= '0;
                r_row_cnt  <= '0;
                r_sum      <= '0;
                r_wp       <= '0;
                r_rp       <= '0;
                r_cnt      <= '0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wp] <= mem_din;
                    r_wp         <= r_wp + PW'(1);
                    r_sum        <= r_sum + mem_din;
                end
                if (w_pop) r_rp <= r_rp + PW'(1);
                r_cnt <= w_cnt_next;
                case (r_state)
                    ISSUE: begin
                        if (r_mem_rd) begin
                            r_mem_rd <= 1'b0;
                            r_state  <= WAIT;
                            r_last   <= r_span_cnt == r_span && r_row_cnt == r_repeat;
                            r_span_cnt <= r_span_cnt == r_span ? 16'd0 : r_span_cnt + 16'd1;
                            r_row_cnt  <= r_span_cnt == r_span ? r_row_cnt + 16'd1 : r_row_cnt;
                            r_addr     <= r_addr + (r_span_cnt == r_span ? r_skip : 16'd1);
                        end else begin
                            r_mem_rd <= w_room;
                        end
                    end
                    WAIT: begin
                        if (mem_valid) begin
                            r_state  <= r_last ? IDLE : ISSUE;
                            r_mem_rd <= !r_last && w_room;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rect_reader.sv
// tb_rect_reader: directed checks of the rect_reader walk order, FIFO flow control,
// checksum, busy lockout and reset behaviour against a latency-programmable memory model.
module tb_rect_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic [1:0]  wr = 2'b00;
    logic [15:0] address = 16'h0, din = 16'h0;
    logic        mem_valid, rd_active, mem_rd;
    logic [15:0] mem_din, mem_addr, dout;

    int n_chk = 0, n_pass = 0;
    int lat = 2, cd = 0;
    int cyc = 0, nrd = 0, nv = 0, last_v = -1;
    logic [15:0] addr_log [256];
    int          rd_cyc [256];
    logic [15:0] pend;
    logic [15:0] d;
    int b, pc, v0;
    logic [15:0] e1 [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                            16'h1103, 16'h1104, 16'h1105, 16'h1106};

    rect_reader dut (
        .clk(clk), .reset(reset), .rd_active(rd_active), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_din(mem_din),
        .wr(wr), .rd(rd), .address(address), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    // Bus monitor: values seen at a rising edge belong to the cycle that edge closes.
    always @(posedge clk) begin
        if (mem_rd) begin
            addr_log[nrd] = mem_addr;
            rd_cyc[nrd] = cyc;
            nrd++;
        end
        if (mem_valid) begin
            nv++;
            last_v = cyc;
        end
        cyc++;
    end

    // Memory model: returns addr^0x5A5A exactly lat cycles after each mem_rd.
    initial begin
        mem_valid = 1'b0;
        mem_din = 16'h0;
        pend = 16'h0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_valid = 1'b1;
                    mem_din = pend ^ 16'h5A5A;
                end
            end
            if (mem_rd) begin
                cd = lat;
                pend = mem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wreg(input logic [3:0] a, input logic [15:0] v, input logic [1:0] m = 2'b11);
        address = {12'h000, a};
        din = v;
        wr = m;
        @(negedge clk);
        wr = 2'b00;
    endtask

    task automatic rreg(input logic [3:0] a, output logic [15:0] v);
        address = {12'h000, a};
        rd = 1'b0;
        @(negedge clk);
        v = dout;
    endtask

    task automatic pop(output logic [15:0] v);
        address = 16'h0005;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        v = dout;
    endtask

    task automatic run(input logic [15:0] sp, sk, rp, st);
        wreg(4'd0, sp);
        wreg(4'd1, sk);
        wreg(4'd2, rp);
        wreg(4'd3, st);
        wreg(4'd7, 16'h0001);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (rd_active && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("walk_done", {31'b0, rd_active}, 32'd0);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        chk("rst_active", {31'b0, rd_active}, 32'd0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_dout", {16'h0, dout}, 32'h0);
        rreg(4'd6, d); chk("rst_status", {16'h0, d}, 32'h0002);
        rreg(4'd4, d); chk("rst_sum", {16'h0, d}, 32'h0000);

        // Basic walk, latency 2
        lat = 2;
        b = nrd;
        run(16'd3, 16'h0100, 16'd1, 16'h1000);
        chk("t1_first_active", {31'b0, rd_active}, 32'd1);
        chk("t1_first_rd", {31'b0, mem_rd}, 32'd1);
        chk("t1_first_addr", {16'h0, mem_addr}, 32'h1000);
        wait_idle();
        chk("t1_fall_cycle", cyc, last_v + 1);
        chk("t1_reads", nrd - b, 32'd8);
        for (int i = 0; i < 8; i++) chk("t1_addr", {16'h0, addr_log[b + i]}, {16'h0, e1[i]});
        chk("t1_gap", rd_cyc[b + 1] - rd_cyc[b], 32'd3);
        rreg(4'd4, d); chk("t1_sum", {16'h0, d}, 32'h56D8);
        rreg(4'd6, d); chk("t1_status_full", {16'h0, d}, 32'h0084);
        for (int i = 0; i < 8; i++) begin
            pop(d);
            chk("t1_data", {16'h0, d}, {16'h0, e1[i] ^ 16'h5A5A});
        end
        rreg(4'd6, d); chk("t1_status_empty", {16'h0, d}, 32'h0002);

        // FIFO backpressure: 12 words, no pops until stalled
        lat = 1;
        b = nrd;
        run(16'd3, 16'd1, 16'd2, 16'h2000);
        step(40);
        chk("t2_reads_stalled", nrd - b, 32'd8);
        rreg(4'd6, d); chk("t2_status_stall", {16'h0, d}, 32'h0085);
        pc = cyc;
        for (int i = 0; i < 4; i++) begin
            pop(d);
            chk("t2_data_a", {16'h0, d}, {16'h0, (16'h2000 + 16'(i)) ^ 16'h5A5A});
        end
        chk("t2_resume_cycle", rd_cyc[b + 8], pc + 1);
        step(40);
        chk("t2_reads_total", nrd - b, 32'd12);
        chk("t2_done", {31'b0, rd_active}, 32'd0);
        rreg(4'd6, d); chk("t2_status_end", {16'h0, d}, 32'h0084);
        for (int i = 4; i < 12; i++) begin
            pop(d);
            chk("t2_data_b", {16'h0, d}, {16'h0, (16'h2000 + 16'(i)) ^ 16'h5A5A});
        end

        // Wrap and minimum size
        lat = 1;
        b = nrd;
        run(16'd0, 16'd0, 16'd0, 16'hFFFF);
        wait_idle();
        chk("t3_one_read", nrd - b, 32'd1);
        chk("t3_addr", {16'h0, addr_log[b]}, 32'hFFFF);
        pop(d); chk("t3_data", {16'h0, d}, 32'hA5A5);
        b = nrd;
        wreg(4'd0, 16'd2);
        wreg(4'd3, 16'h12FE, 2'b01);
        rreg(4'd3, d); chk("t3_bytemask", {16'h0, d}, 32'hFFFE);
        wreg(4'd7, 16'h0001);
        wait_idle();
        chk("t3_wrap_reads", nrd - b, 32'd3);
        chk("t3_wrap_a0", {16'h0, addr_log[b]}, 32'hFFFE);
        chk("t3_wrap_a1", {16'h0, addr_log[b + 1]}, 32'hFFFF);
        chk("t3_wrap_a2", {16'h0, addr_log[b + 2]}, 32'h0000);
        pop(d); chk("t3_wrap_d0", {16'h0, d}, 32'hA5A4);
        pop(d); chk("t3_wrap_d1", {16'h0, d}, 32'hA5A5);
        pop(d); chk("t3_wrap_d2", {16'h0, d}, 32'h5A5A);

        // Busy lockout
        lat = 3;
        b = nrd;
        run(16'd3, 16'd1, 16'd1, 16'h3000);
        step(4);
        chk("t4_busy", {31'b0, rd_active}, 32'd1);
        wreg(4'd0, 16'd7);
        wreg(4'd7, 16'h0001);
        wait_idle();
        chk("t4_reads", nrd - b, 32'd8);
        chk("t4_last_addr", {16'h0, addr_log[b + 7]}, 32'h3007);
        rreg(4'd0, d); chk("t4_span_kept", {16'h0, d}, 32'h0003);
        rreg(4'd6, d); chk("t4_status", {16'h0, d}, 32'h0084);
        for (int i = 0; i < 8; i++) begin
            pop(d);
            chk("t4_data", {16'h0, d}, {16'h0, (16'h3000 + 16'(i)) ^ 16'h5A5A});
        end

        // Reset while a read is outstanding; its data arrives afterwards
        lat = 6;
        run(16'd3, 16'd1, 16'd0, 16'h4000);
        chk("t5_rd_issued", {31'b0, mem_rd}, 32'd1);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_active", {31'b0, rd_active}, 32'd0);
        chk("t5_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("t5_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("t5_dout", {16'h0, dout}, 32'h0);
        b = nrd;
        v0 = nv;
        step(12);
        chk("t5_late_valid_seen", nv - v0, 32'd1);
        chk("t5_no_reads", nrd - b, 32'd0);
        chk("t5_still_idle", {31'b0, rd_active}, 32'd0);
        rreg(4'd6, d); chk("t5_status", {16'h0, d}, 32'h0002);
        rreg(4'd4, d); chk("t5_sum", {16'h0, d}, 32'h0000);
        rreg(4'd0, d); chk("t5_span_reset", {16'h0, d}, 32'h0000);

        // Empty pop, then a pop coinciding with the final push at count 1
        pop(d); chk("t6_empty_pop", {16'h0, d}, 32'h0000);
        rreg(4'd6, d); chk("t6_empty_status", {16'h0, d}, 32'h0002);
        lat = 3;
        run(16'd1, 16'd0, 16'd0, 16'h5000);
        step(7);
        pc = cyc;
        pop(d); chk("t6_pop_head", {16'h0, d}, 32'h0A5A);
        chk("t6_same_cycle", last_v, pc);
        rreg(4'd6, d); chk("t6_status_cnt1", {16'h0, d}, 32'h0010);
        rreg(4'd4, d); chk("t6_sum", {16'h0, d}, 32'h14B5);
        pop(d); chk("t6_pop_second", {16'h0, d}, 32'h0A5B);
        rreg(4'd6, d); chk("t6_status_end", {16'h0, d}, 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
